// File: rtl/pl_hazard_unit.sv
// Pipeline hazard unit: EX/store-data forwarding, load-use and multiply/divide stalls, branch flushes.
// Forwarding is combinational; stall/flush sequencing runs from a small FSM with saturating perf counters.
module pl_hazard_unit #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  IF_ID_rs,
  input  logic [RA_W-1:0]  IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic [RA_W-1:0]  ID_EX_rs,
  input  logic [RA_W-1:0]  ID_EX_rt,
  input  logic [RA_W-1:0]  ID_EX_rd,
  input  logic             ID_EX_mem_read,
  input  logic [RA_W-1:0]  EX_MEM_rd,
  input  logic [RA_W-1:0]  MEM_WB_rd,
  input  logic [RA_W-1:0]  EX_MEM_rt,
  input  logic             EX_MEM_reg_write,
  input  logic             MEM_WB_reg_write,
  input  logic             EX_MEM_mem_read,
  input  logic             EX_MEM_mem_write,
  input  logic             branch_taken,
  input  logic             md_start,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             forward_store_data,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, LU_STALL, MD_WAIT} state_t;

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       lu;

  // A load in MEM has no data yet, so the EX_MEM path is skipped and WB may still supply it.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (EX_MEM_reg_write && (EX_MEM_rd != '0) && (EX_MEM_rd == src) && !EX_MEM_mem_read)
      sel = 2'b10;
    else if (MEM_WB_reg_write && (MEM_WB_rd != '0) && (MEM_WB_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    forward_a          = 2'b00;
    forward_b          = 2'b00;
    forward_store_data = 1'b0;
    if (rst_n) begin
      forward_a          = fwd_sel(ID_EX_rs);
      forward_b          = fwd_sel(ID_EX_rt);
      forward_store_data = EX_MEM_mem_write && MEM_WB_reg_write &&
                           (MEM_WB_rd != '0) && (MEM_WB_rd == EX_MEM_rt);
    end
  end

  assign lu = ID_EX_mem_read && (ID_EX_rd != '0) &&
              ((ID_EX_rd == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rd == IF_ID_rt)));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    md_busy     = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (md_start) begin
          md_busy   = 1'b1;
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          cnt_nxt   = 6'(MD_LAT - 2);
          state_nxt = MD_WAIT;
        end else if (lu) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          flush_id_ex = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_nxt   = 6'(LOAD_LAT - 2);
            state_nxt = LU_STALL;
          end
        end
      end
      LU_STALL: begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        flush_id_ex = 1'b1;
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 6'd1;
      end
      MD_WAIT: begin
        md_busy  = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 6'd1;
      end
      default: state_nxt = RUN;
    endcase
    // Control outputs are held quiet for the whole reset window, not just after the edge.
    if (!rst_n) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      md_busy     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_if && !(&stall_cycles))
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_if_id && !(&flush_count))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
